// File: rtl/bpsk_modulator_top.sv
// bpsk_modulator_top: transmit-side BPSK modulator with a one-deep input holding register
//
// Takes data bits through a valid/ready handshake. Each bit is held for SAMPLES_PER_SYMBOL
// clocks and emitted as signed carrier samples from a cosine table: +cos for bit 0, -cos for
// bit 1. The phase accumulator free-runs in every state, so the carrier is continuous across
// symbols, idle gaps and back-to-back bursts.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   bit_in     data bit to transmit
//   bit_valid  bit_in is valid
//   bit_ready  block can accept a bit this cycle (combinational)
//   data_out   registered signed modulated sample
//   out_valid  data_out carries a data-symbol sample
//   busy       a symbol is being sent or the holding register is full
//
// Configuration macro BPSK_DIFF_ENC_EN: when defined, bits are differentially encoded
// (DBPSK). The reference bit restarts at 0 at the beginning of every burst.
//
// The embedded cosine table has 16 entries of 16-bit Q1.15 samples, scaled by 32768 and
// clipped at the top. The negative peak is therefore the most-negative code, so the
// saturating negation is actually exercised.
module bpsk_modulator_top #(
    parameter int SAMPLING_FREQ              = 100_000_000,
    parameter int CARRIER_FREQ               = 12_500_000,
    parameter int SAMPLES_PER_SYMBOL         = 8,
    parameter int CARRIER_SAMPLES_PER_PERIOD = 16,
    parameter int FIXDT_64_A_WIDTH           = 16,
    parameter int PHASE_STEP                 = CARRIER_SAMPLES_PER_PERIOD / (SAMPLING_FREQ / CARRIER_FREQ),
    parameter bit IDLE_CARRIER               = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               bit_in,
    input  logic                               bit_valid,
    output logic                               bit_ready,
    output logic signed [FIXDT_64_A_WIDTH-1:0] data_out,
    output logic                               out_valid,
    output logic                               busy
);
    localparam int AW = $clog2(CARRIER_SAMPLES_PER_PERIOD);
    localparam int CW = SAMPLES_PER_SYMBOL > 1 ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam int W  = FIXDT_64_A_WIDTH;
    localparam logic [AW-1:0] STEP = AW'(PHASE_STEP);
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic signed [W-1:0] MAX_CODE = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_CODE = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [15:0] COS_LUT [16] = '{
        16'sd32767,  16'sd30274,  16'sd23170,  16'sd12540,
        16'sd0,     -16'sd12540, -16'sd23170, -16'sd30274,
        16'sh8000,  -16'sd30274, -16'sd23170, -16'sd12540,
        16'sd0,      16'sd12540,  16'sd23170,  16'sd30274
    };

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state, state_n;
    logic [AW-1:0]         lu_angle;
    logic [CW-1:0]         sym_cnt, cnt_n;
    logic                  hold_bit, hold_bit_n, hold_full, hold_full_n;
    logic                  sym, sym_n, sym_enc;
    logic                  last, load_now, accept;
    logic signed [W-1:0]   cos_val, neg_val, sample_n;

    assign last      = sym_cnt == LAST;
    assign load_now  = hold_full && (state == IDLE || last);
    assign bit_ready = !hold_full || load_now;
    assign accept    = bit_valid && bit_ready;
    assign busy      = state == ACTIVE || hold_full;
    assign cos_val   = COS_LUT[lu_angle];
    // Two's-complement negation of the most-negative code would wrap; clamp it instead.
    assign neg_val   = (cos_val == MIN_CODE) ? MAX_CODE : -cos_val;

`ifdef BPSK_DIFF_ENC_EN
    logic diff_ref;
    // Reference follows the last transmitted symbol; returning to IDLE starts a new burst at 0.
    always_ff @(posedge clk) begin
        diff_ref <= rst ? 1'b0 : load_now ? sym_enc : (state == ACTIVE && last) ? 1'b0 : diff_ref;
    end
    assign sym_enc = diff_ref ^ hold_bit;
`else
    assign sym_enc = hold_bit;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = sym_cnt;
        sym_n       = sym;
        hold_full_n = accept || (hold_full && !load_now);
        hold_bit_n  = accept ? bit_in : hold_bit;
        if (load_now) begin
            state_n = ACTIVE;
            cnt_n   = '0;
            sym_n   = sym_enc;
        end else if (state == ACTIVE) begin
            state_n = last ? IDLE : ACTIVE;
            cnt_n   = last ? '0 : sym_cnt + 1'b1;
        end
        sample_n = (state == ACTIVE) ? (sym ? neg_val : cos_val) : (IDLE_CARRIER ? cos_val : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lu_angle  <= '0;
            sym_cnt   <= '0;
            hold_full <= 1'b0;
            hold_bit  <= 1'b0;
            sym       <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            lu_angle  <= lu_angle + STEP;
            sym_cnt   <= cnt_n;
            hold_full <= hold_full_n;
            hold_bit  <= hold_bit_n;
            sym       <= sym_n;
            data_out  <= sample_n;
            out_valid <= state == ACTIVE;
        end
    end
endmodule
